pipe_ctrl: RTL

Central pipeline controller for the 5-stage MIPS core. It merges per-stage stall requests into the `CTRL_WIDTH stall vector consumed by the PC and the pipeline registers. It sequences exception flushes, deferring them while a memory access is stalling, and drives the PC redirect. It also keeps a saturating stall-cycle counter and a sticky stall-timeout flag for debug.

---
 rtl/pipe_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences exception
// flushes with PC redirect, and tracks stall statistics for debug.
module pipe_ctrl #(
    parameter int CTRL_WIDTH      = 6,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_stall_req,
    input  logic                       id_stall_req,
    input  logic                       ex_stall_req,
    input  logic                       mem_stall_req,
    input  logic                       exc_req,
    input  logic [INST_ADDR_WIDTH-1:0] exc_vector,
    output logic [CTRL_WIDTH-1:0]      stall,
    output logic                       flush,
    output logic                       exc_ack,
    output logic                       new_pc_valid,
    output logic [INST_ADDR_WIDTH-1:0] new_pc,
    output logic [CNT_WIDTH-1:0]       stall_cycles,
    output logic                       stall_timeout
);

    localparam int                RUN_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic                       r_flush;
    logic [INST_ADDR_WIDTH-1:0] r_new_pc;
    logic [CNT_WIDTH-1:0]       r_stall_cycles;
    logic [RUN_W-1:0]           r_run;
    logic                       r_timeout;
    logic [CTRL_WIDTH-1:0]      w_stall_merge;
    logic [CTRL_WIDTH-1:0]      w_stall;

    // Deepest stalled stage holds itself and everything upstream of it.
    always_comb begin
        w_stall_merge = '0;
        if (mem_stall_req)
            w_stall_merge = CTRL_WIDTH'(5'b11111);
        else if (ex_stall_req)
            w_stall_merge = CTRL_WIDTH'(4'b1111);
        else if (id_stall_req)
            w_stall_merge = CTRL_WIDTH'(3'b111);
        else if (if_stall_req)
            w_stall_merge = CTRL_WIDTH'(2'b11);
    end

    // The flush cycle must let the redirect through, and reset forces the vector low.
    assign w_stall = (rst || r_flush) ? '0 : w_stall_merge;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (exc_req)
                    w_state_nxt = mem_stall_req ? S_PENDING : S_FLUSH;
            end
            S_PENDING: begin
                if (!exc_req)
                    w_state_nxt = S_IDLE;
                else if (!mem_stall_req)
                    w_state_nxt = S_FLUSH;
            end
            S_FLUSH:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_flush        <= 1'b0;
            r_new_pc       <= '0;
            r_stall_cycles <= '0;
            r_run          <= '0;
            r_timeout      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_flush <= (w_state_nxt == S_FLUSH);
            if (w_state_nxt == S_FLUSH)
                r_new_pc <= exc_vector;

            if (w_stall != '0) begin
                if (r_stall_cycles != '1)
                    r_stall_cycles <= r_stall_cycles + 1'b1;
                if (r_run < RUN_MAX)
                    r_run <= r_run + 1'b1;
                // This edge completes the TIMEOUT_CYCLES-th consecutive stalled cycle.
                if (r_run >= RUN_MAX - 1'b1)
                    r_timeout <= 1'b1;
            end else begin
                r_run <= '0;
            end
        end
    end

    assign stall         = w_stall;
    assign flush         = r_flush;
    assign exc_ack       = r_flush;
    assign new_pc_valid  = r_flush;
    assign new_pc        = r_new_pc;
    assign stall_cycles  = r_stall_cycles;
    assign stall_timeout = r_timeout;

endmodule
